// File: rtl/serial_rx_fifo.sv
// Oversampled serial receiver with majority-vote bit recovery, configurable frame
// format, per-frame error flags and a first-word-fall-through receive FIFO.
module serial_rx_fifo #(
    parameter int DATA_BITS  = 7,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_parity_err,
    output logic                 rd_frame_err,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_next;
    logic                 sync_meta, line, line_prev;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 samp_a, samp_b, maj;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_err, frame_err;
    logic                 start_edge, win_end, decide, last_stop;
    logic                 push_req, push_ok, pop, full;
    logic [EW-1:0]        push_entry, head;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;

    // Synchroniser flops reset low so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            line      <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            sync_meta <= data_in;
            line      <= sync_meta;
            line_prev <= line;
        end
    end

    assign start_edge = !line && line_prev;
    assign win_end    = (cnt == CW'(OVERSAMPLE - 1));
    assign decide     = (cnt == CW'(M + 1));
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
    assign maj        = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);
    assign push_entry = {shreg, parity_err, frame_err | !maj};
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) state_next = ST_START;
            end
            ST_START: begin
                if (decide && maj) state_next = ST_IDLE;
                else if (win_end)  state_next = ST_DATA;
            end
            ST_DATA: begin
                if (win_end && bit_cnt == BW'(DATA_BITS - 1))
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (win_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (decide && last_stop) begin
                    push_req   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The edge-detect cycle counts as sample 0 of the start window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            samp_a     <= 1'b0;
            samp_b     <= 1'b0;
            shreg      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state_next == ST_IDLE)  cnt <= '0;
            else if (state == ST_IDLE)  cnt <= CW'(1);
            else if (win_end)           cnt <= '0;
            else                        cnt <= cnt + CW'(1);

            if (cnt == CW'(M - 1)) samp_a <= line;
            if (cnt == CW'(M))     samp_b <= line;

            case (state)
                ST_START: begin
                    bit_cnt    <= '0;
                    stop_cnt   <= 1'b0;
                    parity_err <= 1'b0;
                    frame_err  <= 1'b0;
                end
                ST_DATA: begin
                    if (decide)  shreg   <= {maj, shreg[DATA_BITS-1:1]};
                    if (win_end) bit_cnt <= bit_cnt + BW'(1);
                end
                ST_PARITY: begin
                    if (decide) parity_err <= maj ^ (^shreg) ^ (PARITY == 2);
                end
                ST_STOP: begin
                    if (decide && !maj) frame_err <= 1'b1;
                    if (win_end)        stop_cnt  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign full     = (count == (AW + 1)'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            overrun <= push_req && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wr_ptr] <= push_entry;
    end

    assign head          = mem[rd_ptr];
    assign rd_data       = rd_valid ? head[EW-1:2] : '0;
    assign rd_parity_err = rd_valid ? head[1] : 1'b0;
    assign rd_frame_err  = rd_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench: three receiver instances (even 7-bit, odd 7-bit, 8-bit no parity)
// share one serial line; each has its own expected-entry queue fed by a frame model.
module tb_serial_rx_fifo;

  logic clk;
  logic reset;
  logic data_in;

  logic [6:0] rd_data;
  logic       rd_parity_err, rd_frame_err, rd_valid, rd_ready, overrun, busy;
  logic [6:0] rd_data_o;
  logic       rd_parity_err_o, rd_frame_err_o, rd_valid_o, rd_ready_o, overrun_o, busy_o;
  logic [7:0] rd_data_8;
  logic       rd_parity_err_8, rd_frame_err_8, rd_valid_8, rd_ready_8, overrun_8, busy_8;

  logic [10:0] exp_q[$];
  logic [10:0] exp_qo[$];
  logic [10:0] exp_q8[$];

  int n_assert = 0;
  int n_fail   = 0;
  int ov_cnt_8 = 0;

  serial_rx_fifo dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .overrun(overrun), .busy(busy)
  );

  serial_rx_fifo #(.PARITY(2)) dut_odd (
    .clk(clk), .reset(reset), .data_in(data_in),
    .rd_data(rd_data_o), .rd_parity_err(rd_parity_err_o), .rd_frame_err(rd_frame_err_o),
    .rd_valid(rd_valid_o), .rd_ready(rd_ready_o), .overrun(overrun_o), .busy(busy_o)
  );

  serial_rx_fifo #(.DATA_BITS(8), .PARITY(0)) dut_8 (
    .clk(clk), .reset(reset), .data_in(data_in),
    .rd_data(rd_data_8), .rd_parity_err(rd_parity_err_8), .rd_frame_err(rd_frame_err_8),
    .rd_valid(rd_valid_8), .rd_ready(rd_ready_8), .overrun(overrun_8), .busy(busy_8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame bit 0 is the start bit; expected entry is {data[8:0], parity_err, frame_err}
  function automatic logic [10:0] model(input logic [9:0] fr, input int db, input int par);
    logic [8:0] d;
    logic pe, fe;
    int idx;
    d = '0;
    for (int i = 0; i < db; i++) d[i] = fr[1 + i];
    idx = 1 + db;
    pe = 1'b0;
    if (par != 0) begin
      pe = fr[idx] != ((^d) ^ (par == 2));
      idx++;
    end
    fe = !fr[idx];
    return {d, pe, fe};
  endfunction

  function automatic logic [9:0] mk7(input logic [6:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  function automatic logic [9:0] mk8(input logic [7:0] d, input logic s);
    return {s, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_bits(input int n);
    repeat (n * 16) begin
      @(posedge clk); #1;
      data_in = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [9:0] fr, input int nbits, input int glitch_bit);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        data_in = (b == glitch_bit && c == 8) ? ~fr[b] : fr[b];
      end
    end
  endtask

  task automatic push_all(input logic [9:0] fr, input logic to8);
    exp_q.push_back(model(fr, 7, 1));
    exp_qo.push_back(model(fr, 7, 2));
    if (to8) exp_q8.push_back(model(fr, 8, 0));
  endtask

  task automatic frame(input logic [9:0] fr, input int glitch_bit);
    push_all(fr, 1'b1);
    send_bits(fr, 10, glitch_bit);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() + exp_qo.size() + exp_q8.size()) != 0; i++)
      @(negedge clk);
    check(tag, exp_q.size() + exp_qo.size() + exp_q8.size(), 0);
  endtask

  // scoreboard: compare each popped head entry with the front of its queue
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_even unexpected entry observed=%0h", {2'b0, rd_data, rd_parity_err, rd_frame_err});
      end
      if (exp_q.size() != 0) check("pop_even", {2'b0, rd_data, rd_parity_err, rd_frame_err}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && rd_valid_o && rd_ready_o) begin
      n_assert++;
      assert (exp_qo.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_odd unexpected entry observed=%0h", {2'b0, rd_data_o, rd_parity_err_o, rd_frame_err_o});
      end
      if (exp_qo.size() != 0) check("pop_odd", {2'b0, rd_data_o, rd_parity_err_o, rd_frame_err_o}, exp_qo.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && rd_valid_8 && rd_ready_8) begin
      n_assert++;
      assert (exp_q8.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_8bit unexpected entry observed=%0h", {1'b0, rd_data_8, rd_parity_err_8, rd_frame_err_8});
      end
      if (exp_q8.size() != 0) check("pop_8bit", {1'b0, rd_data_8, rd_parity_err_8, rd_frame_err_8}, exp_q8.pop_front());
    end
    if (!reset && overrun_8) ov_cnt_8++;
  end

  initial begin
    int seen;
    reset = 1'b1;
    data_in = 1'b1;
    rd_ready = 1'b1;
    rd_ready_o = 1'b1;
    rd_ready_8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_parity_err", rd_parity_err, 0);
    check("reset_rd_frame_err", rd_frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    idle_bits(2);

    // two back-to-back characters with a short idle gap
    frame(mk7(7'h4B, 1'b0, 1'b1), -1);
    @(negedge clk);
    check("busy_between_frames", busy, 0);
    idle_bits(1);
    frame(mk7(7'h0D, 1'b1, 1'b1), -1);
    idle_bits(1);

    // wrong even parity, then a glitch on the middle sample of a data bit
    frame(mk7(7'h4B, 1'b1, 1'b1), -1);
    idle_bits(1);
    frame(mk7(7'h55, 1'b0, 1'b1), 3);
    idle_bits(1);
    frame(mk7(7'h33, 1'b0, 1'b1), 9);
    idle_bits(1);
    wait_drain("drain_basic");

    // stop bit low, then a long break
    frame(mk7(7'h4B, 1'b0, 1'b0), -1);
    idle_bits(2);
    push_all(10'b0, 1'b1);
    repeat (40 * 16) begin
      @(posedge clk); #1;
      data_in = 1'b0;
    end
    idle_bits(2);
    wait_drain("drain_break");
    frame(mk7(7'h0D, 1'b1, 1'b1), -1);
    idle_bits(1);
    wait_drain("drain_after_break");

    // false start: line low for only 4 cycles
    repeat (4) begin
      @(posedge clk); #1;
      data_in = 1'b0;
    end
    @(posedge clk); #1;
    data_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("false_start_busy_rise", seen, 1);
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    check("false_start_busy_fall", seen, 1);
    idle_bits(1);
    check("false_start_valid_even", rd_valid, 0);
    check("false_start_valid_odd", rd_valid_o, 0);
    check("false_start_valid_8bit", rd_valid_8, 0);

    // overrun on the 8-bit instance with the reader stalled
    ov_cnt_8 = 0;
    rd_ready_8 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push_all(mk8(8'(k), 1'b1), k <= 4);
      send_bits(mk8(8'(k), 1'b1), 10, -1);
      idle_bits(1);
    end
    check("overrun_pulse_cycles", ov_cnt_8, 1);
    check("full_rd_valid_8bit", rd_valid_8, 1);
    rd_ready_8 = 1'b1;
    wait_drain("drain_overrun");
    @(negedge clk);
    check("drained_rd_valid_8bit", rd_valid_8, 0);

    // reset in the middle of a frame, after data bit 3
    send_bits(mk7(7'h4B, 1'b0, 1'b1), 5, -1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    data_in = 1'b1;
    @(negedge clk);
    check("midframe_reset_busy", busy, 0);
    check("midframe_reset_rd_valid", rd_valid, 0);
    idle_bits(2);
    check("midframe_reset_nothing_stored", rd_valid, 0);
    frame(mk7(7'h4B, 1'b0, 1'b1), -1);
    idle_bits(2);
    wait_drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
